// File: rtl/rate_hex_pkg.sv
// rate_hex_pkg: seven-segment digit codes and default tick rates
package rate_hex_pkg;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                          SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  localparam int RATE0_DEF = 1;
  localparam int RATE1_DEF = 50_000_000;
  localparam int RATE2_DEF = 100_000_000;
  localparam int RATE3_DEF = 200_000_000;
endpackage

// File: rtl/hex7seg_decoder.sv
// hex7seg_decoder: one hex nibble to active-low seven-segment pattern
module hex7seg_decoder
  import rate_hex_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[digit];
endmodule

// File: rtl/rate_hex_counter.sv
// rate_hex_counter: rate-divided up/down modulo hex counter driving seven-segment displays
module rate_hex_counter
  import rate_hex_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_COUNT = 2**CNT_W-1,
  parameter int DIV_W     = 28,
  parameter int RATE0     = RATE0_DEF,
  parameter int RATE1     = RATE1_DEF,
  parameter int RATE2     = RATE2_DEF,
  parameter int RATE3     = RATE3_DEF
) (
  input  logic                      CLOCK_50,
  input  logic                      Clear,
  input  logic                      Enable,
  input  logic [1:0]                Rate_sel,
  input  logic                      Up,
  input  logic                      Load,
  input  logic [CNT_W-1:0]          Load_val,
  output logic [CNT_W-1:0]          Count,
  output logic                      Tick,
  output logic                      Wrap,
  output logic [7*(CNT_W/4)-1:0]    HEX
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_COUNT);
  logic [DIV_W-1:0] div_cnt, reload;
  logic [1:0] sel_q;
  logic [CNT_W-1:0] next_count;
  logic do_rate, do_tick, wrap_now;
  always_comb begin
    reload = Rate_sel == 2'd0 ? DIV_W'(RATE0-1) :
             Rate_sel == 2'd1 ? DIV_W'(RATE1-1) :
             Rate_sel == 2'd2 ? DIV_W'(RATE2-1) : DIV_W'(RATE3-1);
    do_rate = !Load && Rate_sel != sel_q;
    do_tick = !Load && !do_rate && Enable && div_cnt == '0;
    wrap_now = Up ? Count == MAX : Count == '0;
    next_count = Up ? (Count >= MAX ? '0 : Count + 1'b1) : (Count == '0 ? MAX : Count - 1'b1);
  end
  // sel_q captures the live selector at reset so power-up is not seen as a rate change
  always_ff @(posedge CLOCK_50 or negedge Clear) begin
    if (!Clear) begin
      div_cnt <= '0;
      sel_q <= Rate_sel;
    end else begin
      sel_q <= Rate_sel;
      if (Load || do_rate || do_tick) div_cnt <= reload;
      else if (Enable) div_cnt <= div_cnt - 1'b1;
    end
  end
  always_ff @(posedge CLOCK_50 or negedge Clear) begin
    if (!Clear) begin
      Count <= '0;
      Tick <= 1'b0;
      Wrap <= 1'b0;
    end else begin
      Tick <= do_tick;
      Wrap <= do_tick && wrap_now;
      Count <= Load ? (Load_val > MAX ? MAX : Load_val) : do_tick ? next_count : Count;
    end
  end
  for (genvar i = 0; i < CNT_W/4; i++) begin : g_hex
    hex7seg_decoder u_dec (.digit(Count[4*i +: 4]), .seg(HEX[7*i +: 7]));
  end
endmodule

// File: tb/tb_rate_hex_counter.sv
// tb_rate_hex_counter: directed vector bench for rate_hex_counter with small rates
module tb_rate_hex_counter;
  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic       up;
    logic [1:0] rs;
    logic [7:0] cnt;
    logic       tk;
    logic       wr;
  } vec_t;
  logic CLOCK_50 = 1'b0, Clear = 1'b0, Enable = 1'b0, Up = 1'b1, Load = 1'b0;
  logic [1:0] Rate_sel = 2'd1;
  logic [7:0] Load_val = 8'd0, Count;
  logic Tick, Wrap;
  logic [13:0] HEX;
  int passed = 0, total = 0;
  vec_t vq[$];
  logic [6:0] seg_tb [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  rate_hex_counter #(.CNT_W(8), .MAX_COUNT(11), .DIV_W(28),
                     .RATE0(1), .RATE1(3), .RATE2(5), .RATE3(8)) dut (
    .CLOCK_50(CLOCK_50), .Clear(Clear), .Enable(Enable), .Rate_sel(Rate_sel), .Up(Up),
    .Load(Load), .Load_val(Load_val), .Count(Count), .Tick(Tick), .Wrap(Wrap), .HEX(HEX)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  function automatic vec_t mk(input logic ld, input logic [7:0] lv, input logic en, input logic up,
                              input logic [1:0] rs, input logic [7:0] cnt, input logic tk, input logic wr);
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = en; v.up = up; v.rs = rs; v.cnt = cnt; v.tk = tk; v.wr = wr;
    return v;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic check_out(input string tag, input logic [7:0] cnt, input logic tk, input logic wr);
    logic [13:0] hx;
    hx = {seg_tb[cnt[7:4]], seg_tb[cnt[3:0]]};
    chk({tag, " count"}, int'(Count), int'(cnt));
    chk({tag, " tick"}, int'(Tick), int'(tk));
    chk({tag, " wrap"}, int'(Wrap), int'(wr));
    chk({tag, " hex"}, int'(HEX), int'(hx));
  endtask
  task automatic step(input vec_t v, input string tag);
    Load = v.ld; Load_val = v.lv; Enable = v.en; Up = v.up; Rate_sel = v.rs;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_out(tag, v.cnt, v.tk, v.wr);
  endtask
  initial begin
    for (int k = 1; k <= 12; k++) vq.push_back(mk(0, 0, 1, 1, 1, 8'((k + 2) / 3), k % 3 == 1, 0));
    vq.push_back(mk(1, 10, 1, 1, 0, 10, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 11, 1, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 1, 1, 0, 1, 1, 0));
    vq.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 11, 1, 1));
    vq.push_back(mk(0, 0, 1, 0, 0, 10, 1, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 9, 1, 0));
    vq.push_back(mk(1, 8'hFF, 1, 0, 3, 11, 0, 0));
    for (int k = 0; k < 7; k++) vq.push_back(mk(0, 0, 1, 1, 3, 11, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 3, 0, 1, 1));
    vq.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 3, 0, 0, 0));
    for (int k = 0; k < 7; k++) vq.push_back(mk(0, 0, 1, 1, 3, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 3, 1, 1, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 3, 1, 0, 0));
    for (int k = 0; k < 7; k++) vq.push_back(mk(0, 0, 1, 1, 3, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 3, 2, 1, 0));
    repeat (2) @(negedge CLOCK_50);
    check_out("reset", 0, 0, 0);
    Clear = 1'b1;
    for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("vec%0d", i + 1));
    for (int k = 0; k < 5; k++) step(mk(0, 0, 0, 1, 3, 2, 0, 0), "frozen");
    for (int k = 0; k < 7; k++) step(mk(0, 0, 1, 1, 3, 2, 0, 0), "resume");
    step(mk(0, 0, 1, 1, 3, 3, 1, 0), "resume tick");
    step(mk(1, 4, 1, 1, 0, 4, 0, 0), "preload");
    step(mk(0, 0, 1, 1, 0, 5, 1, 0), "pre clear");
    Rate_sel = 2'd1;
    #2 Clear = 1'b0;
    #1 check_out("async clear", 0, 0, 0);
    @(negedge CLOCK_50);
    Clear = 1'b1;
    step(mk(0, 0, 1, 1, 1, 1, 1, 0), "post clear first");
    step(mk(0, 0, 1, 1, 1, 1, 0, 0), "post clear a");
    step(mk(0, 0, 1, 1, 1, 1, 0, 0), "post clear b");
    step(mk(0, 0, 1, 1, 1, 2, 1, 0), "post clear second");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
